outmem_write_arbiter: RTL

Shares the single user-side output memory write port of the Ethernet controller between NUM_REQ independent user engines inside the user circuit. Arbitration is round-robin among engines presenting requests. The winning engine's write is captured into a one-entry holding register, which then drives the controller's req/ack handshake. The block sits between the user engines and the outputMemoryWrite* port, in the userInterfaceClock domain.

---
 rtl/outmem_arb_pkg.sv | 20 ++
 rtl/rr_picker.sv | 32 +++
 rtl/outmem_write_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/outmem_arb_pkg.sv
// Shared constants for the output-memory write arbiter: state encoding,
// pointer-width helper and grant counter width/saturation value.
package outmem_arb_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  typedef enum logic {
    STATE_IDLE    = 1'b0,
    STATE_PENDING = 1'b1
  } arb_state_e;

  localparam int             CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority one-hot selector: first requester at or after ptr
// (mod NUM_REQ) wins when en is high.
module rr_picker
  import outmem_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PW      = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PW-1:0]      idx,
  output logic               any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = (int'(ptr) + k) % NUM_REQ;
      if (en && !any && req[j]) begin
        gnt[j] = 1'b1;
        idx    = PW'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/outmem_write_arbiter.sv
// Round-robin share of the output-memory write port across NUM_REQ engines
// via a one-entry holding register. Define OUTMEM_ARB_STATS_EN for grantCount.
module outmem_write_arbiter
  import outmem_arb_pkg::*;
#(
  parameter int NUM_REQ              = 4,
  parameter int OUTMEM_ADDRESS_WIDTH = 13,
  parameter int OUTMEM_BYTE_WIDTH    = 1
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       userRunValue,
  input  logic [NUM_REQ-1:0]                         engReq,
  output logic [NUM_REQ-1:0]                         engAck,
  input  logic [NUM_REQ*OUTMEM_ADDRESS_WIDTH-1:0]    engAdd,
  input  logic [NUM_REQ*OUTMEM_BYTE_WIDTH*8-1:0]     engData,
  input  logic [NUM_REQ*OUTMEM_BYTE_WIDTH-1:0]       engByteMask,
  output logic                                       outputMemoryWriteReq,
  input  logic                                       outputMemoryWriteAck,
  output logic [OUTMEM_ADDRESS_WIDTH-1:0]            outputMemoryWriteAdd,
  output logic [OUTMEM_BYTE_WIDTH*8-1:0]             outputMemoryWriteData,
  output logic [OUTMEM_BYTE_WIDTH-1:0]               outputMemoryWriteByteMask
`ifdef OUTMEM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0]                   grantCount
`endif
);

  localparam int PW = clog2(NUM_REQ);
  localparam int AW = OUTMEM_ADDRESS_WIDTH;
  localparam int DW = OUTMEM_BYTE_WIDTH * 8;
  localparam int MW = OUTMEM_BYTE_WIDTH;

  arb_state_e        state_q, state_d;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     gidx;
  logic              gany;
  logic              slot_free;
  logic              grant_en;

  // A completing write frees the slot in the same cycle, so a new grant can
  // overlap the ack and sustain one write per clock.
  assign slot_free = (state_q == STATE_IDLE) || outputMemoryWriteAck;
  assign grant_en  = slot_free && userRunValue && !reset;

  rr_picker #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
    .req (engReq),
    .ptr (rr_ptr),
    .en  (grant_en),
    .gnt (engAck),
    .idx (gidx),
    .any (gany)
  );

  always_comb begin
    state_d = state_q;
    if (gany)                                               state_d = STATE_PENDING;
    else if (state_q == STATE_PENDING && outputMemoryWriteAck) state_d = STATE_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q                   <= STATE_IDLE;
      rr_ptr                    <= '0;
      outputMemoryWriteAdd      <= '0;
      outputMemoryWriteData     <= '0;
      outputMemoryWriteByteMask <= '0;
    end else begin
      state_q <= state_d;
      if (gany) begin
        outputMemoryWriteAdd      <= engAdd[gidx*AW +: AW];
        outputMemoryWriteData     <= engData[gidx*DW +: DW];
        outputMemoryWriteByteMask <= engByteMask[gidx*MW +: MW];
        rr_ptr                    <= (gidx == PW'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
      end
    end
  end

  assign outputMemoryWriteReq = (state_q == STATE_PENDING);

`ifdef OUTMEM_ARB_STATS_EN
  logic [NUM_REQ-1:0][CNT_W-1:0] cnt;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (reset)                                         cnt[i] <= '0;
      else if (engReq[i] && engAck[i] && cnt[i] != CNT_SAT) cnt[i] <= cnt[i] + 1'b1;
    end
  end

  assign grantCount = cnt;
`endif

endmodule
